cpu_instr_sequencer: RTL and testbench
======================================

Name: cpu_instr_sequencer

Overview:
- Upstream instruction-feed stage for tt_um_4bit_cpu_with_fsm.
- Holds a 16-entry program of {opcode, addr, data} nibble triples and steps a program counter through it.
- Presents each instruction to the CPU on 8-bit buses, nibble in bits [7:4] and [3:0] zero, held long enough for the CPU's IDLE->op->IDLE sequence.
- Supports free-run, single-step and halt.

Parameters:
- HOLD_CYCLES, 3, cycles each instruction is held on the output buses (min 2, max 15).
- HALT_OP, 4'hF, opcode that stops the sequencer; also driven as the inter-instruction gap opcode (CPU treats it as no-op).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- prog_we  in  1  program memory write strobe
- prog_addr  in  4  program memory write address
- prog_wdata  in  12  {opcode[11:8], addr[7:4], data[3:0]}
- start  in  1  single-cycle pulse: begin run from pc=0
- step_mode  in  1  1 = pause after every instruction
- step  in  1  single-cycle pulse: release a paused sequencer
- out_opcode  out  8  {opcode, 4'b0000} to CPU in_opcode_eightBit
- out_addr  out  8  {addr, 4'b0000} to CPU in_addr_eightBit
- out_data  out  8  {data, 4'b0000} to CPU in_data_eightBit
- out_write_ena  out  1  to CPU write_ena
- busy  out  1  high in FETCH/ISSUE/PAUSE
- halted  out  1  high in HALT
- pc  out  4  current program counter

Behaviour:
- Reset: state=IDLE, pc=0, out_opcode=8'hF0, out_addr=0, out_data=0, out_write_ena=0, busy=0, halted=0, hold counter=0.
- Reset does not clear program memory.
- Reset mid-run returns to IDLE on the next edge; outputs revert to reset values on that edge.
- Program write: mem[prog_addr]<=prog_wdata when prog_we and state is IDLE or HALT. Writes are ignored in any other state.
- States: IDLE, FETCH, ISSUE, PAUSE, HALT.
- IDLE/HALT --start--> FETCH, with pc<=0.
  - start together with prog_we: the write commits first, so FETCH of that address reads the new word.
  - start in any other state is ignored.
- FETCH (1 cycle): instr_reg<=mem[pc].
  - If opcode==HALT_OP -> HALT; outputs stay at the gap value.
  - Else -> ISSUE with hold counter=HOLD_CYCLES-1.
- ISSUE (HOLD_CYCLES cycles):
  - Outputs are registered from instr_reg and are valid the cycle after entering ISSUE, so latency from FETCH entry to first valid bus is 2 cycles.
  - out_write_ena=1 for every ISSUE cycle when opcode==4'b0010 (STORE); otherwise 0.
  - When the counter reaches 0:
    - pc==15 -> HALT (no wrap).
    - Else pc<=pc+1, then PAUSE if step_mode, otherwise FETCH.
- Gap: in every state other than ISSUE, out_opcode=8'hF0, out_addr=0, out_data=0, out_write_ena=0. This guarantees at least one gap cycle between instructions, so the CPU FSM returns to IDLE.
- PAUSE: wait for step -> FETCH.
  - step and start asserted together in PAUSE: step wins, start is ignored.
  - step outside PAUSE is ignored.
  - step_mode is sampled only at the end of ISSUE.
- HALT: halted=1, pc holds its last value; leave only via start or rst.

Decomposition:
- Shared package cpu4_pkg:
  - CPU opcode localparams: ADD 0, SUB 1, STORE 2, LOAD 3, AND 5, OR 6, XOR 7, NOT/SHL 8/9, SHR 10, HALT 15.
  - State encoding (3-bit).
  - NIBBLE_W=4.
- One natural sub-module: cpu_prog_mem, a 16x12 synchronous-write, asynchronous-read register file.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: assert rst 2 cycles -> out_opcode=8'hF0, out_write_ena=0, busy=0, halted=0, pc=0.
- Load and free-run: load mem0={3,2,0}, mem1={0,0,5}, mem2={F,0,0}, pulse start.
  - Cycle +2: out_opcode=8'h30, out_addr=8'h20 for 3 cycles.
  - Then gap 8'hF0, then 8'h00 with out_data=8'h50.
  - Then halted=1 with pc=2.
- STORE strobe: mem0={2,7,0}, mem1={F,0,0} -> out_write_ena high for exactly 3 cycles with out_addr=8'h70, otherwise low.
- Single step: step_mode=1, 3-instruction program -> sequencer parks in PAUSE after each instruction (busy=1, outputs 8'hF0); each step pulse issues exactly one more instruction.
- Wrap boundary: all 16 entries ADD (no HALT) -> after issuing pc=15, halted=1, pc=15, no seventeenth issue.
- Write lockout and mid-run reset:
  - prog_we during ISSUE -> memory unchanged (read back on a later run).
  - rst during ISSUE -> IDLE next cycle, outputs at reset values, program intact on next start.

Source files
------------

// File: rtl/cpu4_pkg.sv
// Shared opcodes, sequencer state encoding and bus helpers for the 4-bit CPU
// instruction-feed path.
package cpu4_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [NIBBLE_W-1:0] OP_ADD   = 4'd0;
    localparam logic [NIBBLE_W-1:0] OP_SUB   = 4'd1;
    localparam logic [NIBBLE_W-1:0] OP_STORE = 4'd2;
    localparam logic [NIBBLE_W-1:0] OP_LOAD  = 4'd3;
    localparam logic [NIBBLE_W-1:0] OP_AND   = 4'd5;
    localparam logic [NIBBLE_W-1:0] OP_OR    = 4'd6;
    localparam logic [NIBBLE_W-1:0] OP_XOR   = 4'd7;
    localparam logic [NIBBLE_W-1:0] OP_NOT   = 4'd8;
    localparam logic [NIBBLE_W-1:0] OP_SHL   = 4'd9;
    localparam logic [NIBBLE_W-1:0] OP_SHR   = 4'd10;
    localparam logic [NIBBLE_W-1:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StIssue = 3'd2,
        StPause = 3'd3,
        StHalt  = 3'd4
    } state_t;

    typedef struct packed {
        logic [NIBBLE_W-1:0] opcode;
        logic [NIBBLE_W-1:0] addr;
        logic [NIBBLE_W-1:0] data;
    } instr_t;

    // The CPU samples nibbles in the upper half of its 8-bit input buses.
    function automatic logic [2*NIBBLE_W-1:0] to_bus(input logic [NIBBLE_W-1:0] nib);
        return {nib, {NIBBLE_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cpu_prog_mem.sv
// 16 x 12 program store: synchronous write, asynchronous read, not reset so
// a loaded program survives sequencer resets.
module cpu_prog_mem
    import cpu4_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [NIBBLE_W-1:0]   waddr,
    input  logic [3*NIBBLE_W-1:0] wdata,
    input  logic [NIBBLE_W-1:0]   raddr,
    output logic [3*NIBBLE_W-1:0] rdata
);

    logic [3*NIBBLE_W-1:0] mem [16];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_instr_sequencer.sv
// Instruction-feed sequencer for the 4-bit CPU: steps a 16-entry program and
// holds each instruction on the CPU input buses for HOLD_CYCLES cycles.
module cpu_instr_sequencer
    import cpu4_pkg::*;
#(
    parameter int unsigned         HOLD_CYCLES = 3,
    parameter logic [NIBBLE_W-1:0] HALT_OP     = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [11:0] prog_wdata,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    output logic [7:0]  out_opcode,
    output logic [7:0]  out_addr,
    output logic [7:0]  out_data,
    output logic        out_write_ena,
    output logic        busy,
    output logic        halted,
    output logic [3:0]  pc
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] pc_d;
    logic [3:0] hold_q, hold_d;
    instr_t     instr_q, instr_d;
    instr_t     mem_rdata;
    logic       mem_we;

    logic [7:0] opcode_d, addr_d, data_d;
    logic       write_ena_d;

    // Program may only change while nothing is being fed to the CPU.
    assign mem_we = prog_we && (state_q == StIdle || state_q == StHalt);

    cpu_prog_mem u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        hold_d  = hold_q;
        instr_d = instr_q;
        case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: begin
                instr_d = mem_rdata;
                if (mem_rdata.opcode == HALT_OP) begin
                    state_d = StHalt;
                end else begin
                    state_d = StIssue;
                    hold_d  = HOLD_LAST;
                end
            end
            StIssue: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 4'd1;
                end else if (pc == 4'hF) begin
                    state_d = StHalt;
                end else begin
                    pc_d    = pc + 4'd1;
                    state_d = step_mode ? StPause : StFetch;
                end
            end
            StPause: begin
                if (step) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Buses are registered from the ISSUE state, so they trail it by one cycle;
    // the FETCH that separates instructions still yields a gap cycle on the bus.
    always_comb begin
        opcode_d    = to_bus(HALT_OP);
        addr_d      = '0;
        data_d      = '0;
        write_ena_d = 1'b0;
        if (state_q == StIssue) begin
            opcode_d    = to_bus(instr_q.opcode);
            addr_d      = to_bus(instr_q.addr);
            data_d      = to_bus(instr_q.data);
            write_ena_d = (instr_q.opcode == OP_STORE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pc            <= '0;
            hold_q        <= '0;
            instr_q       <= '0;
            out_opcode    <= to_bus(HALT_OP);
            out_addr      <= '0;
            out_data      <= '0;
            out_write_ena <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc            <= pc_d;
            hold_q        <= hold_d;
            instr_q       <= instr_d;
            out_opcode    <= opcode_d;
            out_addr      <= addr_d;
            out_data      <= data_d;
            out_write_ena <= write_ena_d;
        end
    end

    assign busy   = (state_q == StFetch) || (state_q == StIssue) || (state_q == StPause);
    assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Randomized scoreboard bench for cpu_instr_sequencer: a program-level model
// predicts which words get issued; a monitor checks each bus window.
module tb_cpu_instr_sequencer;

    localparam int unsigned HOLD = 3;
    localparam logic [7:0]  GAP  = 8'hF0;

    typedef struct packed {
        logic [3:0]  pc;
        logic [11:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [11:0] prog_wdata;
    logic        start;
    logic        step_mode;
    logic        step;
    logic [7:0]  out_opcode;
    logic [7:0]  out_addr;
    logic [7:0]  out_data;
    logic        out_write_ena;
    logic        busy;
    logic        halted;
    logic [3:0]  pc;

    cpu_instr_sequencer #(
        .HOLD_CYCLES (HOLD),
        .HALT_OP     (4'hF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_wdata    (prog_wdata),
        .start         (start),
        .step_mode     (step_mode),
        .step          (step),
        .out_opcode    (out_opcode),
        .out_addr      (out_addr),
        .out_data      (out_data),
        .out_write_ena (out_write_ena),
        .busy          (busy),
        .halted        (halted),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    int          runs_seen = 0;
    bit          mon_en    = 1'b0;
    exp_t        exp_q[$];
    logic [11:0] mem_model [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] rand_word();
        logic [3:0] op;
        op = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'($urandom_range(0, 14));
        return {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
    endfunction

    // Monitor: groups consecutive non-gap bus cycles into one issue window.
    initial begin : monitor
        bit         in_run;
        int         run_len;
        logic [7:0] r_op, r_addr, r_data;
        logic [3:0] r_pc;
        bit         stable, we_all_hi, we_any_hi;
        exp_t       e;
        in_run = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) continue;
            if (rst) begin
                in_run = 1'b0;
                continue;
            end
            if (out_opcode != GAP) begin
                if (!in_run) begin
                    in_run    = 1'b1;
                    run_len   = 1;
                    r_op      = out_opcode;
                    r_addr    = out_addr;
                    r_data    = out_data;
                    r_pc      = pc;
                    stable    = 1'b1;
                    we_all_hi = out_write_ena;
                    we_any_hi = out_write_ena;
                end else begin
                    run_len++;
                    if (out_opcode != r_op || out_addr != r_addr || out_data != r_data)
                        stable = 1'b0;
                    we_all_hi = we_all_hi & out_write_ena;
                    we_any_hi = we_any_hi | out_write_ena;
                end
            end else begin
                check("gap_bus_zero", {out_addr, out_data, 7'b0, out_write_ena}, 32'h0);
                if (in_run) begin
                    in_run = 1'b0;
                    runs_seen++;
                    if (exp_q.size() == 0) begin
                        check("issue_expected", 32'h0, 32'h1);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_opcode", r_op, {e.w[11:8], 4'h0});
                        check("issue_addr", r_addr, {e.w[7:4], 4'h0});
                        check("issue_data", r_data, {e.w[3:0], 4'h0});
                        check("issue_hold_len", run_len, HOLD);
                        check("issue_pc", r_pc, e.pc);
                        check("issue_stable", stable, 1);
                        check("issue_write_ena", {we_all_hi, we_any_hi},
                              (e.w[11:8] == 4'd2) ? 2'b11 : 2'b00);
                    end
                end
            end
        end
    end

    // Drive from a negedge; leaves the caller on a negedge.
    task automatic write_word(input logic [3:0] a, input logic [11:0] w);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = w;
        @(negedge clk);
        prog_we    = 1'b0;
        mem_model[a] = w;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_opcode"}, out_opcode, GAP);
        check({tag, "_addr_data_we"}, {out_addr, out_data, out_write_ena}, 0);
    endtask

    task automatic run_program(input bit smode, input bit do_rst);
        int          n, fin_pc, lat, base, t;
        bit          combo;
        logic [11:0] cw;
        step_mode = smode;
        combo     = ($urandom_range(0, 3) == 0);
        if (combo) begin
            // Write and start in the same cycle: FETCH must see the new word.
            cw         = rand_word();
            prog_we    = 1'b1;
            prog_addr  = 4'h0;
            prog_wdata = cw;
            mem_model[0] = cw;
        end
        n = 0;
        while (n < 16 && mem_model[n][11:8] != 4'hF) begin
            exp_q.push_back('{pc: 4'(n), w: mem_model[n]});
            n++;
        end
        fin_pc = (n == 16) ? 15 : n;
        base   = runs_seen;
        start  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        if (n > 0) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (out_opcode == GAP && lat < 10);
            check("first_issue_latency", lat, 2);
        end
        if (do_rst) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check_reset_state("midrun_reset");
            rst = 1'b0;
            exp_q.delete();
            step_mode = 1'b0;
            return;
        end
        if (smode) begin
            for (int k = 0; k < n; k++) begin
                t = 0;
                while (runs_seen < base + k + 1 && t < 80) begin
                    @(negedge clk);
                    t++;
                end
                check("step_issue_in_budget", (runs_seen >= base + k + 1), 1);
                if (runs_seen < base + k + 1) break;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (k != 15) begin
                    check("pause_state", {busy, halted, pc}, {1'b1, 1'b0, 4'(k + 1)});
                    check("pause_bus_gap", out_opcode, GAP);
                    check("pause_issue_count", runs_seen - base, k + 1);
                    step  = 1'b1;
                    start = $urandom_range(0, 1);
                    @(negedge clk);
                    step  = 1'b0;
                    start = 1'b0;
                end
            end
        end else begin
            // Spurious start/step/writes while busy must all be ignored.
            t = 0;
            while (!halted && t < 400) begin
                start   = 1'b0;
                step    = 1'b0;
                prog_we = 1'b0;
                if (busy && $urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 2))
                        0: start = 1'b1;
                        1: step  = 1'b1;
                        default: begin
                            prog_we    = 1'b1;
                            prog_addr  = 4'($urandom_range(0, 15));
                            prog_wdata = rand_word();
                        end
                    endcase
                end
                @(negedge clk);
                t++;
            end
            start   = 1'b0;
            step    = 1'b0;
            prog_we = 1'b0;
        end
        t = 0;
        while (!halted && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("final_halted_busy", {halted, busy}, 2'b10);
        check("final_pc", pc, fin_pc);
        check("final_issue_count", runs_seen - base, n);
        check("final_queue_drained", exp_q.size(), 0);
        check("halt_bus_gap", {out_opcode, out_addr, out_data, out_write_ena}, {GAP, 17'h0});
        exp_q.delete();
        step_mode = 1'b0;
    endtask

    initial begin : stimulus
        rst        = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        start      = 1'b0;
        step_mode  = 1'b0;
        step       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) write_word(4'(i), 12'h000);

        // Load, free-run, halt at pc=2.
        write_word(4'h0, 12'h320);
        write_word(4'h1, 12'h005);
        write_word(4'h2, 12'hF00);
        run_program(1'b0, 1'b0);

        // STORE strobe.
        write_word(4'h0, 12'h270);
        write_word(4'h1, 12'hF00);
        run_program(1'b0, 1'b0);

        // Single step over three instructions.
        write_word(4'h0, 12'h512);
        write_word(4'h1, 12'h234);
        write_word(4'h2, 12'h856);
        write_word(4'h3, 12'hF00);
        run_program(1'b1, 1'b0);

        // No HALT anywhere: stops after pc=15 without wrapping.
        for (int i = 0; i < 16; i++) write_word(4'(i), {4'h0, 4'(i), 4'(15 - i)});
        run_program(1'b0, 1'b0);

        // Reset mid-run, then rerun the untouched program.
        run_program(1'b0, 1'b1);
        run_program(1'b0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            bit smode;
            for (int i = 0; i < 16; i++)
                if ($urandom_range(0, 1) == 1) write_word(4'(i), rand_word());
            if ($urandom_range(0, 9) < 7)
                write_word(4'($urandom_range(0, 15)), {4'hF, 8'($urandom_range(0, 255))});
            smode = $urandom_range(0, 2) == 0;
            run_program(smode, !smode && ($urandom_range(0, 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
